// File: rtl/mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mont_exp_ctrl
// Brief  : Left-to-right square-and-multiply sequencer driving an external
//          Montgomery multiplier; produces x^e mod M in the normal domain.
// Rev    : 1.0  initial release
// ============================================================================
module mont_exp_ctrl #(
    parameter int N  = 512,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [N+1:0]  in_x,
    input  logic [N+1:0]  in_r,
    input  logic [N+1:0]  in_m,
    input  logic [N-1:0]  in_e,
    input  logic [LW-1:0] in_elen,
    output logic          mul_start,
    output logic [N+1:0]  mul_a,
    output logic [N+1:0]  mul_b,
    output logic [N+1:0]  mul_m,
    input  logic [N-1:0]  mul_result,
    input  logic          mul_done,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          busy
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_sq_go    = 3'd1;
    localparam logic [2:0] c_sq_wait  = 3'd2;
    localparam logic [2:0] c_mu_go    = 3'd3;
    localparam logic [2:0] c_mu_wait  = 3'd4;
    localparam logic [2:0] c_fin_go   = 3'd5;
    localparam logic [2:0] c_fin_wait = 3'd6;
    localparam logic [2:0] c_done     = 3'd7;

    localparam logic [LW-1:0] c_elen_max = LW'(N);
    localparam logic [N-1:0]  c_bit0     = N'(1);
    localparam logic [N+1:0]  c_op_one   = (N+2)'(1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic [N+1:0]  r_acc;
    logic [N+1:0]  w_acc_next;
    logic [N+1:0]  r_x;
    logic [N-1:0]  r_e;
    logic [LW-1:0] r_i;
    logic [LW-1:0] w_i_next;
    logic [LW-1:0] w_elen_sat;
    logic [N+1:0]  r_mul_a;
    logic [N+1:0]  r_mul_b;
    logic [N+1:0]  r_mul_m;
    logic [N-1:0]  r_result;
    logic          w_accept;
    logic          w_ebit;
    logic          w_last_bit;
    logic [N+1:0]  w_product;

    assign w_accept   = (r_state == c_idle) && start;
    assign w_elen_sat = (in_elen > c_elen_max) ? c_elen_max : in_elen;
    assign w_ebit     = |(r_e & (c_bit0 << r_i));
    assign w_last_bit = (r_i == '0);
    assign w_product  = {2'b00, mul_result};

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_i_next     = r_i;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_acc_next = in_r;
                    if (w_elen_sat != '0) begin
                        w_i_next     = w_elen_sat - LW'(1);
                        w_state_next = c_sq_go;
                    end else begin
                        w_i_next     = '0;
                        w_state_next = c_fin_go;
                    end
                end
            end
            c_sq_go:  w_state_next = c_sq_wait;
            c_sq_wait: begin
                if (mul_done) begin
                    w_acc_next = w_product;
                    if (w_ebit) begin
                        w_state_next = c_mu_go;
                    end else if (w_last_bit) begin
                        w_state_next = c_fin_go;
                    end else begin
                        w_i_next     = r_i - LW'(1);
                        w_state_next = c_sq_go;
                    end
                end
            end
            c_mu_go:  w_state_next = c_mu_wait;
            c_mu_wait: begin
                if (mul_done) begin
                    w_acc_next = w_product;
                    if (w_last_bit) begin
                        w_state_next = c_fin_go;
                    end else begin
                        w_i_next     = r_i - LW'(1);
                        w_state_next = c_sq_go;
                    end
                end
            end
            c_fin_go: w_state_next = c_fin_wait;
            c_fin_wait: begin
                if (mul_done) begin
                    w_state_next = c_done;
                end
            end
            c_done:   w_state_next = c_idle;
            default:  w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_idle;
            r_acc   <= '0;
            r_i     <= '0;
            r_x     <= '0;
            r_e     <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_i     <= w_i_next;
            if (w_accept) begin
                r_x <= in_x;
                r_e <= in_e;
            end
        end
    end

    // Operands are loaded on entry to a GO state so they are already stable
    // in the cycle mul_start is raised and stay put until the next entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_mul_m <= '0;
        end else begin
            if (w_accept) begin
                r_mul_m <= in_m;
            end
            if (w_state_next != r_state) begin
                case (w_state_next)
                    c_sq_go: begin
                        r_mul_a <= w_acc_next;
                        r_mul_b <= w_acc_next;
                    end
                    c_mu_go: begin
                        r_mul_a <= w_acc_next;
                        r_mul_b <= r_x;
                    end
                    c_fin_go: begin
                        r_mul_a <= w_acc_next;
                        r_mul_b <= c_op_one;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_result <= '0;
        end else if ((r_state == c_fin_wait) && mul_done) begin
            r_result <= mul_result;
        end
    end

    assign mul_start = (r_state == c_sq_go) || (r_state == c_mu_go) || (r_state == c_fin_go);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_m     = r_mul_m;
    assign result    = r_result;
    assign done      = (r_state == c_done);
    assign busy      = (r_state != c_idle) && (r_state != c_done);

endmodule
`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mont_exp_ctrl
// Brief  : Scoreboard bench for mont_exp_ctrl with a behavioural Montgomery
//          multiplier responder and a plain modular-exponentiation reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mont_exp_ctrl;
    localparam int N  = 512;
    localparam int LW = 10;

    typedef logic [2*N+7:0] wide_t;
    typedef struct { int kind; bit first; } kind_t;
    typedef struct { logic [N-1:0] res; int ntx; int base; } sb_t;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [N+1:0]  in_x, in_r, in_m;
    logic [N-1:0]  in_e;
    logic [LW-1:0] in_elen;
    logic          mul_start;
    logic [N+1:0]  mul_a, mul_b, mul_m;
    logic [N-1:0]  mul_result;
    logic          mul_done;
    logic [N-1:0]  result;
    logic          done, busy;

    int total, bad, txn_total, n_done, spur_req, last_ntx;
    bit fast_lat;
    logic [N+1:0] cur_x, cur_r, cur_m;
    kind_t kq[$];
    sb_t   sbq[$];

    mont_exp_ctrl #(.N(N), .LW(LW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result), .mul_done(mul_done),
        .result(result), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N+1:0] act, input logic [N+1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // a*b/2^N mod m, reduced bit by bit
    function automatic logic [N-1:0] mont(input logic [N+1:0] a, input logic [N+1:0] b, input logic [N+1:0] m);
        wide_t t;
        t = wide_t'(a) * wide_t'(b);
        for (int k = 0; k < N; k++) begin
            if (t[0]) t = t + wide_t'(m);
            t = t >> 1;
        end
        if (t >= wide_t'(m)) t = t - wide_t'(m);
        return N'(t);
    endfunction

    function automatic logic [N+1:0] to_mont(input logic [N-1:0] v, input logic [N+1:0] m);
        return (N+2)'((wide_t'(v) << N) % wide_t'(m));
    endfunction

    // right-to-left binary exponentiation over the low eff bits of e
    function automatic logic [N-1:0] modexp(input logic [N-1:0] b0, input logic [N-1:0] e, input int eff, input logic [N+1:0] m);
        wide_t res, base, mw;
        mw   = wide_t'(m);
        res  = wide_t'(1) % mw;
        base = wide_t'(b0) % mw;
        for (int k = 0; k < eff; k++) begin
            if (e[k]) res = (res * base) % mw;
            base = (base * base) % mw;
        end
        return N'(res);
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] v;
        for (int k = 0; k < N/32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [N+1:0] rand_mod();
        logic [N-1:0] v;
        v = rand_n();
        v[N-1] = 1'b1;
        v[0]   = 1'b1;
        return {2'b00, v};
    endfunction

    task automatic issue(input logic [N+1:0] m, input logic [N-1:0] xn, input logic [N-1:0] e, input int elen);
        int eff, ones;
        kind_t k;
        sb_t s;
        logic [N-1:0] xr;
        eff  = (elen > N) ? N : elen;
        xr   = N'(wide_t'(xn) % wide_t'(m));
        ones = 0;
        cur_m = m;
        cur_x = to_mont(xr, m);
        cur_r = to_mont(N'(1), m);
        for (int i = eff - 1; i >= 0; i--) begin
            k.kind = 0; k.first = (i == eff - 1); kq.push_back(k);
            if (e[i]) begin
                ones++;
                k.kind = 1; k.first = 1'b0; kq.push_back(k);
            end
        end
        k.kind = 2; k.first = (eff == 0); kq.push_back(k);
        s.res  = modexp(xr, e, eff, m);
        s.ntx  = eff + ones + 1;
        s.base = txn_total;
        sbq.push_back(s);
        last_ntx = s.ntx;
        @(negedge clk);
        in_x = cur_x; in_r = cur_r; in_m = m; in_e = e; in_elen = LW'(elen);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        kq.delete();
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int target, cyc, budget;
        target = n_done + 1;
        cyc    = 0;
        budget = last_ntx * 50 + 100;
        while (n_done < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (n_done < target) begin
            total++; bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
            do_reset();
        end
        @(negedge clk);
    endtask

    task automatic wait_mul_starts(input int n, input int budget);
        int seen, cyc;
        seen = 0;
        cyc  = 0;
        while (1) begin
            if (mul_start) seen++;
            if (seen >= n || cyc >= budget) break;
            @(negedge clk);
            cyc++;
        end
        total++;
        if (seen < n) begin
            bad++;
            $display("FAIL wait_mul_start: saw %0d want %0d", seen, n);
        end
    endtask

    // multiplier responder
    initial begin
        bit pend;
        int cnt, served;
        logic [N-1:0] pv;
        logic [N+1:0] ra, rb, rm, last_prod;
        kind_t k;
        pend = 1'b0; cnt = 0; served = 0; last_prod = '0;
        mul_done = 1'b0; mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("mul_start_overlap", (N+2)'(mul_start), '0);
                cnt--;
                if (cnt == 0) begin
                    check("hold_a", mul_a, ra);
                    check("hold_b", mul_b, rb);
                    check("hold_m", mul_m, rm);
                    mul_result = pv;
                    mul_done   = 1'b1;
                    pend       = 1'b0;
                    last_prod  = {2'b00, pv};
                end
            end else if (mul_start) begin
                txn_total++;
                ra = mul_a; rb = mul_b; rm = mul_m;
                check("mul_m", rm, cur_m);
                if (kq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL txn_kind: unexpected mul_start got 1 want 0");
                end else begin
                    k = kq.pop_front();
                    check("mul_a", ra, k.first ? cur_r : last_prod);
                    case (k.kind)
                        0:       check("sq_b", rb, ra);
                        1:       check("mu_b", rb, cur_x);
                        default: check("fin_b", rb, (N+2)'(1));
                    endcase
                end
                pv   = mont(ra, rb, rm);
                cnt  = fast_lat ? int'($urandom_range(3, 6)) : int'($urandom_range(3, 40));
                pend = 1'b1;
            end else if (spur_req > served) begin
                served++;
                mul_result = N'($urandom);
                mul_done   = 1'b1;
            end
        end
    end

    // scoreboard monitor
    initial begin
        sb_t s;
        forever begin
            @(negedge clk);
            if (resetn && done) begin
                n_done++;
                check("busy_at_done", (N+2)'(busy), '0);
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done want none");
                end else begin
                    s = sbq.pop_front();
                    check("result", {2'b00, result}, {2'b00, s.res});
                    check("txn_count", (N+2)'(txn_total - s.base), (N+2)'(s.ntx));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N+1:0] m;
        total = 0; bad = 0; txn_total = 0; n_done = 0; spur_req = 0; last_ntx = 0;
        fast_lat = 1'b0;
        cur_x = '0; cur_r = '0; cur_m = '0;
        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_elen = '0;
        repeat (3) @(negedge clk);
        check("rst_mul_start", (N+2)'(mul_start), '0);
        check("rst_done", (N+2)'(done), '0);
        check("rst_busy", (N+2)'(busy), '0);
        check("rst_result", {2'b00, result}, '0);
        check("rst_mul_a", mul_a, '0);
        check("rst_mul_b", mul_b, '0);
        check("rst_mul_m", mul_m, '0);
        resetn = 1'b1;
        @(negedge clk);

        issue((N+2)'(13), N'(5), rand_n(), 0);
        wait_done("elen0");

        issue((N+2)'(13), N'(2), N'(5), 3);
        wait_done("e5");
        check("e5_result", {2'b00, result}, (N+2)'(6));

        spur_req++;
        repeat (3) @(negedge clk);
        check("spur_busy", (N+2)'(busy), '0);
        check("spur_mul_start", (N+2)'(mul_start), '0);
        check("spur_mul_b", mul_b, (N+2)'(1));
        check("spur_mul_m", mul_m, (N+2)'(13));
        check("spur_result", {2'b00, result}, (N+2)'(6));

        issue((N+2)'(13), N'(7), N'(11), 4);
        wait_mul_starts(1, 10);
        @(negedge clk);
        in_m = (N+2)'(7); in_x = (N+2)'(3); in_r = (N+2)'(1); in_e = N'(3); in_elen = LW'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_mul_m", mul_m, (N+2)'(13));
        check("ignored_start_busy", (N+2)'(busy), (N+2)'(1));
        wait_done("ignored_start");

        for (int t = 0; t < 6; t++) begin
            m = rand_mod();
            issue(m, rand_n(), rand_n(), int'($urandom_range(1, 24)));
            wait_done("short_rand");
        end

        fast_lat = 1'b1;
        issue(rand_mod(), rand_n(), rand_n(), 1023);
        wait_done("elen_sat");
        fast_lat = 1'b0;

        issue(rand_mod(), rand_n(), rand_n(), N);
        wait_done("full512");

        issue((N+2)'(13), N'(2), N'(6), 3);
        wait_mul_starts(2, 100);
        @(negedge clk);
        resetn = 1'b0;
        kq.delete();
        sbq.delete();
        @(negedge clk);
        check("abort_result", {2'b00, result}, '0);
        check("abort_busy", (N+2)'(busy), '0);
        check("abort_done", (N+2)'(done), '0);
        check("abort_mul_a", mul_a, '0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        issue((N+2)'(7), N'(3), N'(3), 2);
        wait_done("after_abort");
        check("after_abort_result", {2'b00, result}, (N+2)'(6));

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
